// File: rtl/return_address_stack.sv
// Circular return-address stack for IF: push/pop/recover take effect at the next edge; outputs come from registered state only.
// No backpressure: every request is accepted, and pushes when full overwrite the oldest entry. Define RAS_STATS_EN for saturating overflow/underflow counters.
module return_address_stack #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 8,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_en,
   input  logic [XLEN-1:0]  push_addr,
   input  logic             pop_en,
   output logic             ras_valid,
   output logic [XLEN-1:0]  ras_target,
   output logic [PTR_W-1:0] ckpt_tos,
   output logic [PTR_W:0]   ckpt_count,
`ifdef RAS_STATS_EN
   output logic [15:0]      overflow_cnt,
   output logic [15:0]      underflow_cnt,
`endif
   input  logic             recover_en,
   input  logic [PTR_W-1:0] recover_tos,
   input  logic [PTR_W:0]   recover_count
);

   localparam logic [PTR_W:0]   FULL    = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W-1:0] TOS_RST = PTR_W'(DEPTH-1);

   logic [XLEN-1:0]  stack_q [DEPTH];
   logic [PTR_W-1:0] tos_q, tos_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             wr_en;
   logic [PTR_W-1:0] wr_idx;
   logic             empty;

   assign empty = (count_q == '0);

   always_comb begin
      tos_d   = tos_q;
      count_d = count_q;
      wr_en   = 1'b0;
      wr_idx  = tos_q;
      if (recover_en) begin
         tos_d   = recover_tos;
         // A corrupt checkpoint must never push occupancy past the array size.
         count_d = (recover_count > FULL) ? FULL : recover_count;
      end else if (push_en && pop_en && !empty) begin
         wr_en  = 1'b1;
         wr_idx = tos_q;
      end else if (push_en) begin
         tos_d  = tos_q + 1'b1;
         wr_en  = 1'b1;
         wr_idx = tos_q + 1'b1;
         if (count_q != FULL) begin
            count_d = count_q + 1'b1;
         end
      end else if (pop_en && !empty) begin
         tos_d   = tos_q - 1'b1;
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tos_q   <= TOS_RST;
         count_q <= '0;
      end else begin
         tos_q   <= tos_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            stack_q[i] <= '0;
         end
      end else if (wr_en) begin
         stack_q[wr_idx] <= push_addr;
      end
   end

   assign ras_valid  = !empty;
   assign ras_target = stack_q[tos_q];
   assign ckpt_tos   = tos_q;
   assign ckpt_count = count_q;

`ifdef RAS_STATS_EN
   logic [15:0] ovf_cnt_q, udf_cnt_q;
   logic        ovf_inc, udf_inc;

   assign ovf_inc = !recover_en && push_en && !pop_en && (count_q == FULL);
   assign udf_inc = !recover_en && pop_en && !push_en && empty;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ovf_cnt_q <= '0;
         udf_cnt_q <= '0;
      end else begin
         if (ovf_inc && ovf_cnt_q != 16'hFFFF) begin
            ovf_cnt_q <= ovf_cnt_q + 16'd1;
         end
         if (udf_inc && udf_cnt_q != 16'hFFFF) begin
            udf_cnt_q <= udf_cnt_q + 16'd1;
         end
      end
   end

   assign overflow_cnt  = ovf_cnt_q;
   assign underflow_cnt = udf_cnt_q;
`endif

endmodule

// File: tb/tb_return_address_stack.sv
// Self-checking bench for return_address_stack: directed table, corner sequences, randomized run against a reference model.
module tb_return_address_stack;

   localparam int XLEN  = 32;
   localparam int DEPTH = 8;

   logic             clk;
   logic             reset;
   logic             push_en;
   logic [XLEN-1:0]  push_addr;
   logic             pop_en;
   logic             ras_valid;
   logic [XLEN-1:0]  ras_target;
   logic [2:0]       ckpt_tos;
   logic [3:0]       ckpt_count;
   logic             recover_en;
   logic [2:0]       recover_tos;
   logic [3:0]       recover_count;
`ifdef RAS_STATS_EN
   logic [15:0]      overflow_cnt;
   logic [15:0]      underflow_cnt;
`endif

   int checks = 0;
   int errors = 0;

   return_address_stack #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .clk           (clk),
      .reset         (reset),
      .push_en       (push_en),
      .push_addr     (push_addr),
      .pop_en        (pop_en),
      .ras_valid     (ras_valid),
      .ras_target    (ras_target),
      .ckpt_tos      (ckpt_tos),
      .ckpt_count    (ckpt_count),
`ifdef RAS_STATS_EN
      .overflow_cnt  (overflow_cnt),
      .underflow_cnt (underflow_cnt),
`endif
      .recover_en    (recover_en),
      .recover_tos   (recover_tos),
      .recover_count (recover_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One cycle of stimulus; returns 1ns after the edge so outputs are sampled away from it.
   task automatic drive(input bit p, input bit q, input logic [31:0] a,
                        input bit r, input logic [2:0] rt, input logic [3:0] rc);
      push_en = p; pop_en = q; push_addr = a;
      recover_en = r; recover_tos = rt; recover_count = rc;
      @(posedge clk);
      #1;
      push_en = 1'b0; pop_en = 1'b0; recover_en = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
   endtask

   typedef struct {
      bit          push;
      bit          pop;
      logic [31:0] addr;
      bit          rec;
      logic [2:0]  rtos;
      logic [3:0]  rcnt;
      bit          ev;
      logic [31:0] et;
      logic [2:0]  etos;
      logic [3:0]  ecnt;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t mk(bit p, bit q, logic [31:0] a, bit r, logic [2:0] rt, logic [3:0] rc,
                               bit ev, logic [31:0] et, logic [2:0] etos, logic [3:0] ecnt);
      vec_t v;
      v.push = p; v.pop = q; v.addr = a; v.rec = r; v.rtos = rt; v.rcnt = rc;
      v.ev = ev; v.et = et; v.etos = etos; v.ecnt = ecnt;
      return v;
   endfunction

   // Reference model: circular array indexed with modular arithmetic.
   logic [31:0] m_mem [DEPTH];
   int m_tos, m_cnt;
`ifdef RAS_STATS_EN
   int m_ovf, m_udf;
`endif

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_tos = DEPTH - 1;
      m_cnt = 0;
`ifdef RAS_STATS_EN
      m_ovf = 0; m_udf = 0;
`endif
   endtask

   task automatic model_step(input bit p, input bit q, input logic [31:0] a,
                             input bit r, input int rt, input int rc);
      if (r) begin
         m_tos = rt;
         m_cnt = rc;
      end else if (p && q && m_cnt > 0) begin
         m_mem[m_tos] = a;
      end else if (p) begin
`ifdef RAS_STATS_EN
         if (!q && m_cnt == DEPTH && m_ovf < 65535) m_ovf++;
`endif
         m_tos = (m_tos + 1) % DEPTH;
         m_mem[m_tos] = a;
         if (m_cnt < DEPTH) m_cnt++;
      end else if (q) begin
         if (m_cnt > 0) begin
            m_tos = (m_tos + DEPTH - 1) % DEPTH;
            m_cnt--;
         end
`ifdef RAS_STATS_EN
         else if (m_udf < 65535) m_udf++;
`endif
      end
   endtask

   initial begin
      int sv_tos, sv_cnt;
      push_en = 0; pop_en = 0; push_addr = '0;
      recover_en = 0; recover_tos = '0; recover_count = '0;

      // Directed table; expectations hand-derived from the stack rules.
      vt.push_back(mk(1,0,32'h100,0,0,0, 1,32'h100,3'd0,4'd1));
      vt.push_back(mk(1,0,32'h200,0,0,0, 1,32'h200,3'd1,4'd2));
      vt.push_back(mk(1,0,32'h300,0,0,0, 1,32'h300,3'd2,4'd3));
      vt.push_back(mk(0,1,32'h0,  0,0,0, 1,32'h200,3'd1,4'd2));
      vt.push_back(mk(0,1,32'h0,  0,0,0, 1,32'h100,3'd0,4'd1));
      vt.push_back(mk(0,1,32'h0,  0,0,0, 0,32'h0,  3'd7,4'd0));
      vt.push_back(mk(0,1,32'h0,  0,0,0, 0,32'h0,  3'd7,4'd0));
      vt.push_back(mk(1,0,32'hA0, 0,0,0, 1,32'hA0, 3'd0,4'd1));
      vt.push_back(mk(1,0,32'hB0, 0,0,0, 1,32'hB0, 3'd1,4'd2));
      vt.push_back(mk(1,1,32'hC0, 0,0,0, 1,32'hC0, 3'd1,4'd2));
      vt.push_back(mk(0,1,32'h0,  0,0,0, 1,32'hA0, 3'd0,4'd1));
      vt.push_back(mk(1,0,32'hB0, 0,0,0, 1,32'hB0, 3'd1,4'd2));
      vt.push_back(mk(1,0,32'hD0, 0,0,0, 1,32'hD0, 3'd2,4'd3));
      vt.push_back(mk(0,1,32'h0,  0,0,0, 1,32'hB0, 3'd1,4'd2));
      vt.push_back(mk(0,1,32'h0,  0,0,0, 1,32'hA0, 3'd0,4'd1));
      vt.push_back(mk(1,0,32'hEE, 1,3'd1,4'd2, 1,32'hB0,3'd1,4'd2));
      vt.push_back(mk(0,1,32'h0,  0,0,0, 1,32'hA0, 3'd0,4'd1));
      vt.push_back(mk(0,1,32'h0,  0,0,0, 0,32'h0,  3'd7,4'd0));
      vt.push_back(mk(1,1,32'h77, 0,0,0, 1,32'h77, 3'd0,4'd1));
      vt.push_back(mk(0,1,32'h0,  1,3'd5,4'd0, 0,32'h0,3'd5,4'd0));

      do_reset();
      chk("reset_valid", 32'(ras_valid), 32'd0);
      chk("reset_target", ras_target, 32'd0);
      chk("reset_tos", 32'(ckpt_tos), 32'd7);
      chk("reset_count", 32'(ckpt_count), 32'd0);

      for (int i = 0; i < vt.size(); i++) begin
         drive(vt[i].push, vt[i].pop, vt[i].addr, vt[i].rec, vt[i].rtos, vt[i].rcnt);
         chk($sformatf("vec%0d_valid", i), 32'(ras_valid), 32'(vt[i].ev));
         chk($sformatf("vec%0d_target", i), ras_target, vt[i].et);
         chk($sformatf("vec%0d_tos", i), 32'(ckpt_tos), 32'(vt[i].etos));
         chk($sformatf("vec%0d_count", i), 32'(ckpt_count), 32'(vt[i].ecnt));
      end

      // Overflow wrap: nine pushes into eight entries loses the oldest.
      do_reset();
      for (int i = 0; i < 9; i++) drive(1, 0, 32'h1000 + 32'(4*i), 0, 0, 0);
      chk("ovf_count", 32'(ckpt_count), 32'd8);
      chk("ovf_top", ras_target, 32'h1020);
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("ovf_pop%0d_target", k), ras_target, 32'h1020 - 32'(4*k));
         drive(0, 1, 0, 0, 0, 0);
      end
      chk("ovf_empty_valid", 32'(ras_valid), 32'd0);
      drive(0, 1, 0, 0, 0, 0);
      chk("underflow_valid", 32'(ras_valid), 32'd0);
      chk("underflow_count", 32'(ckpt_count), 32'd0);
      chk("underflow_tos", 32'(ckpt_tos), 32'd0);
`ifdef RAS_STATS_EN
      chk("stat_ovf", 32'(overflow_cnt), 32'd1);
      chk("stat_udf", 32'(underflow_cnt), 32'd1);
`endif

      // Asynchronous reset between edges.
      drive(1, 0, 32'h40, 0, 0, 0);
      drive(1, 0, 32'h50, 0, 0, 0);
      chk("pre_areset_target", ras_target, 32'h50);
      #2 reset = 1'b0;
      #1;
      chk("areset_valid", 32'(ras_valid), 32'd0);
      chk("areset_target", ras_target, 32'd0);
      chk("areset_tos", 32'(ckpt_tos), 32'd7);
      chk("areset_count", 32'(ckpt_count), 32'd0);
`ifdef RAS_STATS_EN
      chk("areset_stat_ovf", 32'(overflow_cnt), 32'd0);
`endif
      @(negedge clk);
      reset = 1'b1;
      #1;
      drive(1, 0, 32'h60, 0, 0, 0);
      chk("post_areset_target", ras_target, 32'h60);
      chk("post_areset_count", 32'(ckpt_count), 32'd1);

      // Randomized run against the reference model.
      do_reset();
      model_reset();
      sv_tos = m_tos; sv_cnt = m_cnt;
      for (int c = 0; c < 3000; c++) begin
         bit p, q, r;
         logic [31:0] a;
         p = ($urandom_range(0, 99) < 50);
         q = ($urandom_range(0, 99) < 50);
         r = ($urandom_range(0, 15) == 0);
         a = $urandom;
         if ($urandom_range(0, 7) == 0) begin
            sv_tos = m_tos; sv_cnt = m_cnt;
         end
         drive(p, q, a, r, 3'(sv_tos), 4'(sv_cnt));
         model_step(p, q, a, r, sv_tos, sv_cnt);
         chk("rnd_valid", 32'(ras_valid), 32'(m_cnt != 0));
         chk("rnd_target", ras_target, m_mem[m_tos]);
         chk("rnd_tos", 32'(ckpt_tos), 32'(m_tos));
         chk("rnd_count", 32'(ckpt_count), 32'(m_cnt));
`ifdef RAS_STATS_EN
         chk("rnd_stat_ovf", 32'(overflow_cnt), 32'(m_ovf));
         chk("rnd_stat_udf", 32'(underflow_cnt), 32'(m_udf));
`endif
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
